// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel-in / window-out handshake bundle for the Sobel window generator.
interface sobel_window_gen_if;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [71:0] win_out;
  logic        win_valid;
  logic        win_ready;
  logic        frame_done;
  modport slave (
    input  pix_in, pix_valid, pix_sof, win_ready,
    output pix_ready, win_out, win_valid, frame_done
  );
  modport master (
    output pix_in, pix_valid, pix_sof, win_ready,
    input  pix_ready, win_out, win_valid, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: two line buffers plus a 3-column shift window, emitting a 3x3 neighbourhood
// for every interior pixel of a raster stream.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 7,
  parameter int RW    = 7
) (
  input logic               clk,
  input logic               reset,
  sobel_window_gen_if.slave bus
);
  localparam int AW = $clog2(IMG_W);
  typedef enum logic {FILL, RUN} state_t;
  state_t        state_q;
  logic [CW-1:0] col_q, col_d, pcol;
  logic [RW-1:0] row_q, row_d, prow;
  logic [7:0]    lb_top [IMG_W];
  logic [7:0]    lb_mid [IMG_W];
  logic [7:0]    top, mid;
  logic [23:0]   c0_q, c1_q, c2_q;
  logic [71:0]   win_q;
  logic          valid_q, fd_q;
  logic          acc, last_col, last_row, emit;
  assign bus.pix_ready  = !valid_q | bus.win_ready;
  assign bus.win_out    = win_q;
  assign bus.win_valid  = valid_q;
  assign bus.frame_done = fd_q;
  assign acc      = bus.pix_valid & bus.pix_ready;
  // A start-of-frame pixel is (0,0) whatever the counters say.
  assign pcol     = bus.pix_sof ? '0 : col_q;
  assign prow     = bus.pix_sof ? '0 : row_q;
  assign last_col = pcol == CW'(IMG_W - 1);
  assign last_row = prow == RW'(IMG_H - 1);
  assign col_d    = last_col ? '0 : pcol + CW'(1);
  assign row_d    = last_col ? (last_row ? '0 : prow + RW'(1)) : prow;
  assign top      = lb_top[pcol[AW-1:0]];
  assign mid      = lb_mid[pcol[AW-1:0]];
  // RUN already implies row>=2 for the current pixel unless sof just forced it back to row 0.
  assign emit     = acc & (state_q == RUN) & !bus.pix_sof & (pcol >= CW'(2));
  always_ff @(posedge clk) begin
    if (acc) begin
      lb_top[pcol[AW-1:0]] <= mid;
      lb_mid[pcol[AW-1:0]] <= bus.pix_in;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      fd_q    <= acc & last_col & last_row;
      valid_q <= emit ? 1'b1 : (bus.win_ready ? 1'b0 : valid_q);
      if (emit) win_q <= {c1_q, c2_q, top, mid, bus.pix_in};
      if (acc) begin
        col_q   <= col_d;
        row_q   <= row_d;
        state_q <= (row_d >= RW'(2)) ? RUN : FILL;
        c0_q    <= c1_q;
        c1_q    <= c2_q;
        c2_q    <= {top, mid, bus.pix_in};
      end
    end
  end
endmodule
